// File: rtl/mem_access_if.sv
// Data-memory port of the memory stage: a request that is held high until a
// single-cycle acknowledge, with the read data valid in the acknowledge cycle.
interface mem_access_if #(
    parameter int XLEN = 64
);
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [7:0]      dmem_wmask;
    logic [XLEN-1:0] dmem_wdata;
    logic            dmem_ack;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wmask, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wmask, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_access.sv
// RV64 memory stage. Takes EX results, runs loads/stores over the dmem
// req/ack port, and registers the writeback/forwarding (mem_back_*) bus.
// Upstream is stalled (ready_o=0) while an access is outstanding; an access
// that sees no acknowledge within TIMEOUT_CYC cycles is aborted with bus_err_o.
// Optional feature macro MEM_MISALIGN_TRAP_EN: misaligned accesses are not
// issued and are flagged on misalign_o; without it, low address bits beyond
// the access size are ignored.
module mem_access #(
    parameter int XLEN        = 64,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid_i,
    output logic              ready_o,
    input  logic [6:0]        opcode_i,
    input  logic [2:0]        funct3_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [XLEN-1:0]   store_data_i,
    input  logic [4:0]        rd_addr_i,
    input  logic              wreg_i,
    input  logic [11:0]       csr_waddr_i,
    input  logic              csr_wreg_i,
    input  logic [XLEN-1:0]   csr_wdata_i,
    mem_access_if.master      dmem,
    output logic              wb_valid_o,
    output logic [4:0]        mem_back_rd_addr_o,
    output logic              mem_back_wreg_o,
    output logic [XLEN-1:0]   mem_back_wdata_o,
    output logic [11:0]       mem_back_csr_waddr_o,
    output logic              mem_back_csr_wreg_o,
    output logic [XLEN-1:0]   mem_back_csr_wdata_o,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic              misalign_o,
`endif
    output logic              bus_err_o
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Byte offset actually used for an access: bits below the access size are dropped.
    function automatic logic [2:0] f_eff_off(input logic [1:0] size, input logic [2:0] off);
        logic [2:0] r;
        case (size)
            2'b00:   r = off;
            2'b01:   r = {off[2:1], 1'b0};
            2'b10:   r = {off[2], 2'b00};
            2'b11:   r = 3'b000;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

`ifdef MEM_MISALIGN_TRAP_EN
    // An access is misaligned when its offset is not a multiple of its size.
    function automatic logic f_misaligned(input logic [1:0] size, input logic [2:0] off);
        logic r;
        case (size)
            2'b00:   r = 1'b0;
            2'b01:   r = off[0];
            2'b10:   r = (off[1:0] != 2'b00);
            2'b11:   r = (off != 3'b000);
            default: r = 1'b0;
        endcase
        return r;
    endfunction
`endif

    // Byte enables for a store of the given size at the given lane.
    function automatic logic [7:0] f_store_mask(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] r;
        case (size)
            2'b00:   r = 8'h01 << off;
            2'b01:   r = 8'h03 << off;
            2'b10:   r = 8'h0F << off;
            2'b11:   r = 8'hFF;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Extract and sign/zero-extend the addressed lane of an aligned 8-byte read.
    function automatic logic [XLEN-1:0] f_load_ext(input logic [XLEN-1:0] rdata,
                                                   input logic [2:0] f3,
                                                   input logic [2:0] off);
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] r;
        sh = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  r = {{(XLEN-8){sh[7]}},   sh[7:0]};
            3'b001:  r = {{(XLEN-16){sh[15]}}, sh[15:0]};
            3'b010:  r = {{(XLEN-32){sh[31]}}, sh[31:0]};
            3'b011:  r = sh;
            3'b100:  r = {{(XLEN-8){1'b0}},    sh[7:0]};
            3'b101:  r = {{(XLEN-16){1'b0}},   sh[15:0]};
            3'b110:  r = {{(XLEN-32){1'b0}},   sh[31:0]};
            default: r = {XLEN{1'b0}};
        endcase
        return r;
    endfunction

    state_t          r_state;
    logic            r_ready;
    logic [7:0]      r_cnt;

    logic            r_req;
    logic            r_we;
    logic [XLEN-1:0] r_addr;
    logic [7:0]      r_wmask;
    logic [XLEN-1:0] r_wdata;

    logic            r_cap_load;
    logic [2:0]      r_cap_f3;
    logic [2:0]      r_cap_off;
    logic [4:0]      r_cap_rd;
    logic            r_cap_wreg;
    logic [XLEN-1:0] r_cap_wdata;
    logic [11:0]     r_cap_csr_waddr;
    logic            r_cap_csr_wreg;
    logic [XLEN-1:0] r_cap_csr_wdata;

    logic            r_wb_valid;
    logic [4:0]      r_back_rd;
    logic            r_back_wreg;
    logic [XLEN-1:0] r_back_wdata;
    logic [11:0]     r_back_csr_waddr;
    logic            r_back_csr_wreg;
    logic [XLEN-1:0] r_back_csr_wdata;
    logic            r_bus_err;
`ifdef MEM_MISALIGN_TRAP_EN
    logic            r_misalign;
    logic            w_misalign;
`endif

    logic            w_is_load;
    logic            w_is_store;
    logic            w_is_mem;
    logic            w_f3_ok;
    logic            w_mem_ok;
    logic [2:0]      w_off;
    logic            w_rd_wreg;

    // Classify the incoming EX result and decide whether it may go to memory.
    always_comb begin
        w_is_load  = (opcode_i == OP_LOAD);
        w_is_store = (opcode_i == OP_STORE);
        w_is_mem   = w_is_load | w_is_store;
        w_f3_ok    = w_is_store ? (funct3_i[2] == 1'b0) : (funct3_i != 3'b111);
        w_off      = f_eff_off(funct3_i[1:0], wdata_i[2:0]);
        w_rd_wreg  = wreg_i & (rd_addr_i != 5'd0);
`ifdef MEM_MISALIGN_TRAP_EN
        w_misalign = f_misaligned(funct3_i[1:0], wdata_i[2:0]);
        w_mem_ok   = w_f3_ok & ~w_misalign;
`else
        w_mem_ok   = w_f3_ok;
`endif
    end

    // Stage FSM: accepts EX results, sequences the dmem handshake and registers writeback outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state          <= ST_IDLE;
            r_ready          <= 1'b1;
            r_cnt            <= 8'd0;
            r_req            <= 1'b0;
            r_we             <= 1'b0;
            r_addr           <= {XLEN{1'b0}};
            r_wmask          <= 8'h00;
            r_wdata          <= {XLEN{1'b0}};
            r_cap_load       <= 1'b0;
            r_cap_f3         <= 3'b000;
            r_cap_off        <= 3'b000;
            r_cap_rd         <= 5'd0;
            r_cap_wreg       <= 1'b0;
            r_cap_wdata      <= {XLEN{1'b0}};
            r_cap_csr_waddr  <= 12'd0;
            r_cap_csr_wreg   <= 1'b0;
            r_cap_csr_wdata  <= {XLEN{1'b0}};
            r_wb_valid       <= 1'b0;
            r_back_rd        <= 5'd0;
            r_back_wreg      <= 1'b0;
            r_back_wdata     <= {XLEN{1'b0}};
            r_back_csr_waddr <= 12'd0;
            r_back_csr_wreg  <= 1'b0;
            r_back_csr_wdata <= {XLEN{1'b0}};
            r_bus_err        <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            r_misalign       <= 1'b0;
`endif
        end else begin
            // Pulse-type outputs and write enables are only high alongside wb_valid.
            r_wb_valid      <= 1'b0;
            r_back_wreg     <= 1'b0;
            r_back_csr_wreg <= 1'b0;
            r_bus_err       <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            r_misalign      <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (ex_valid_i && r_ready) begin
                        if (w_is_mem && w_mem_ok) begin
                            r_cap_load      <= w_is_load;
                            r_cap_f3        <= funct3_i;
                            r_cap_off       <= w_off;
                            r_cap_rd        <= rd_addr_i;
                            r_cap_wreg      <= w_rd_wreg & w_is_load;
                            r_cap_wdata     <= wdata_i;
                            r_cap_csr_waddr <= csr_waddr_i;
                            r_cap_csr_wreg  <= csr_wreg_i;
                            r_cap_csr_wdata <= csr_wdata_i;
                            r_req           <= 1'b1;
                            r_we            <= w_is_store;
                            r_addr          <= {wdata_i[XLEN-1:3], 3'b000};
                            r_wmask         <= w_is_store ? f_store_mask(funct3_i[1:0], w_off) : 8'h00;
                            r_wdata         <= w_is_store ? (store_data_i << {w_off, 3'b000}) : {XLEN{1'b0}};
                            r_cnt           <= 8'd0;
                            r_ready         <= 1'b0;
                            r_state         <= ST_REQ;
                        end else begin
                            // ALU/CSR result, or a memory op that must not be issued.
                            r_wb_valid       <= 1'b1;
                            r_back_rd        <= rd_addr_i;
                            r_back_wreg      <= w_rd_wreg & ~w_is_mem;
                            r_back_wdata     <= wdata_i;
                            r_back_csr_waddr <= csr_waddr_i;
                            r_back_csr_wreg  <= csr_wreg_i;
                            r_back_csr_wdata <= csr_wdata_i;
`ifdef MEM_MISALIGN_TRAP_EN
                            r_misalign       <= w_is_mem & w_f3_ok & w_misalign;
`endif
                        end
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (dmem.dmem_ack) begin
                        r_req            <= 1'b0;
                        r_we             <= 1'b0;
                        r_wmask          <= 8'h00;
                        r_wb_valid       <= 1'b1;
                        r_back_rd        <= r_cap_rd;
                        r_back_wreg      <= r_cap_wreg;
                        r_back_wdata     <= r_cap_load ? f_load_ext(dmem.dmem_rdata, r_cap_f3, r_cap_off)
                                                       : r_cap_wdata;
                        r_back_csr_waddr <= r_cap_csr_waddr;
                        r_back_csr_wreg  <= r_cap_csr_wreg;
                        r_back_csr_wdata <= r_cap_csr_wdata;
                        r_state          <= ST_RESP;
                    end else if (r_cnt == TO_LAST) begin
                        // No acknowledge in time: abort without any register write.
                        r_req            <= 1'b0;
                        r_we             <= 1'b0;
                        r_wmask          <= 8'h00;
                        r_wb_valid       <= 1'b1;
                        r_bus_err        <= 1'b1;
                        r_back_rd        <= r_cap_rd;
                        r_back_wdata     <= {XLEN{1'b0}};
                        r_back_csr_waddr <= r_cap_csr_waddr;
                        r_back_csr_wdata <= r_cap_csr_wdata;
                        r_ready          <= 1'b1;
                        r_state          <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_req   <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready_o              = r_ready;
    assign dmem.dmem_req        = r_req;
    assign dmem.dmem_we         = r_we;
    assign dmem.dmem_addr       = r_addr;
    assign dmem.dmem_wmask      = r_wmask;
    assign dmem.dmem_wdata      = r_wdata;
    assign wb_valid_o           = r_wb_valid;
    assign mem_back_rd_addr_o   = r_back_rd;
    assign mem_back_wreg_o      = r_back_wreg;
    assign mem_back_wdata_o     = r_back_wdata;
    assign mem_back_csr_waddr_o = r_back_csr_waddr;
    assign mem_back_csr_wreg_o  = r_back_csr_wreg;
    assign mem_back_csr_wdata_o = r_back_csr_wdata;
    assign bus_err_o            = r_bus_err;
`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign_o           = r_misalign;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access.
module tb_mem_access;
    localparam int XLEN = 64;
    localparam logic [63:0] RDATA = 64'hF0E1_D2C3_B4A5_9687;

    logic            clk = 1'b0;
    logic            rst;
    logic            ex_valid_i;
    logic            ready_o;
    logic [6:0]      opcode_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] wdata_i;
    logic [XLEN-1:0] store_data_i;
    logic [4:0]      rd_addr_i;
    logic            wreg_i;
    logic [11:0]     csr_waddr_i;
    logic            csr_wreg_i;
    logic [XLEN-1:0] csr_wdata_i;
    logic            wb_valid_o;
    logic [4:0]      mem_back_rd_addr_o;
    logic            mem_back_wreg_o;
    logic [XLEN-1:0] mem_back_wdata_o;
    logic [11:0]     mem_back_csr_waddr_o;
    logic            mem_back_csr_wreg_o;
    logic [XLEN-1:0] mem_back_csr_wdata_o;
    logic            bus_err_o;
`ifdef MEM_MISALIGN_TRAP_EN
    logic            misalign_o;
`endif

    int checks   = 0;
    int failures = 0;

    // Load table: funct3, address, expected result for rdata RDATA.
    logic [2:0]  ld_f3   [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b110, 3'b011};
    logic [63:0] ld_addr [7] = '{64'h1000, 64'h1001, 64'h1002, 64'h1006, 64'h1004, 64'h1000, 64'h1000};
    logic [63:0] ld_exp  [7] = '{64'hFFFF_FFFF_FFFF_FF87, 64'h0000_0000_0000_0096,
                                 64'hFFFF_FFFF_FFFF_B4A5, 64'h0000_0000_0000_F0E1,
                                 64'hFFFF_FFFF_F0E1_D2C3, 64'h0000_0000_B4A5_9687,
                                 64'hF0E1_D2C3_B4A5_9687};

    // Store table: funct3, address, data, expected mask and lane data.
    logic [2:0]  st_f3    [4] = '{3'b000, 3'b001, 3'b010, 3'b011};
    logic [63:0] st_addr  [4] = '{64'h2003, 64'h2006, 64'h2004, 64'h2008};
    logic [63:0] st_data  [4] = '{64'h11, 64'hBEEF, 64'hCAFE_BABE, 64'h0123_4567_89AB_CDEF};
    logic [7:0]  st_mask  [4] = '{8'h08, 8'hC0, 8'hF0, 8'hFF};
    logic [63:0] st_lane  [4] = '{64'h0000_0000_1100_0000, 64'hBEEF_0000_0000_0000,
                                  64'hCAFE_BABE_0000_0000, 64'h0123_4567_89AB_CDEF};

    mem_access_if #(.XLEN(XLEN)) mif ();

    mem_access #(.XLEN(XLEN), .TIMEOUT_CYC(255)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .ex_valid_i           (ex_valid_i),
        .ready_o              (ready_o),
        .opcode_i             (opcode_i),
        .funct3_i             (funct3_i),
        .wdata_i              (wdata_i),
        .store_data_i         (store_data_i),
        .rd_addr_i            (rd_addr_i),
        .wreg_i               (wreg_i),
        .csr_waddr_i          (csr_waddr_i),
        .csr_wreg_i           (csr_wreg_i),
        .csr_wdata_i          (csr_wdata_i),
        .dmem                 (mif),
        .wb_valid_o           (wb_valid_o),
        .mem_back_rd_addr_o   (mem_back_rd_addr_o),
        .mem_back_wreg_o      (mem_back_wreg_o),
        .mem_back_wdata_o     (mem_back_wdata_o),
        .mem_back_csr_waddr_o (mem_back_csr_waddr_o),
        .mem_back_csr_wreg_o  (mem_back_csr_wreg_o),
        .mem_back_csr_wdata_o (mem_back_csr_wdata_o),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign_o           (misalign_o),
`endif
        .bus_err_o            (bus_err_o)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        ex_valid_i   = 1'b0;
        opcode_i     = 7'b0010011;
        funct3_i     = 3'b000;
        wdata_i      = 64'h0;
        store_data_i = 64'h0;
        rd_addr_i    = 5'd0;
        wreg_i       = 1'b0;
        csr_waddr_i  = 12'h000;
        csr_wreg_i   = 1'b0;
        csr_wdata_i  = 64'h0;
    endtask

    task automatic drive_op(input logic [6:0] op, input logic [2:0] f3, input logic [63:0] wd,
                            input logic [63:0] sd, input logic [4:0] rd, input logic we);
        ex_valid_i   = 1'b1;
        opcode_i     = op;
        funct3_i     = f3;
        wdata_i      = wd;
        store_data_i = sd;
        rd_addr_i    = rd;
        wreg_i       = we;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        idle_inputs();
        mif.dmem_ack   = 1'b0;
        mif.dmem_rdata = 64'h0;
        #12;
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
        checks++; if (wb_valid_o !== 1'b0) begin failures++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid_o); end
        checks++; if (mif.dmem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", mif.dmem_req); end
        checks++; if (mem_back_wdata_o !== 64'h0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", mem_back_wdata_o); end
        checks++; if (bus_err_o !== 1'b0) begin failures++; $display("FAIL reset_bus_err got=%b exp=0", bus_err_o); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_alu;
        drive_op(7'b0110011, 3'b000, 64'h1234, 64'h0, 5'd5, 1'b1);
        csr_waddr_i = 12'h300; csr_wreg_i = 1'b1; csr_wdata_i = 64'hAA;
        tick();
        idle_inputs();
        checks++; if (wb_valid_o !== 1'b1) begin failures++; $display("FAIL alu_wb_valid got=%b exp=1", wb_valid_o); end
        checks++; if (mem_back_wdata_o !== 64'h1234) begin failures++; $display("FAIL alu_wdata got=%h exp=1234", mem_back_wdata_o); end
        checks++; if (mem_back_wreg_o !== 1'b1) begin failures++; $display("FAIL alu_wreg got=%b exp=1", mem_back_wreg_o); end
        checks++; if (mem_back_rd_addr_o !== 5'd5) begin failures++; $display("FAIL alu_rd got=%0d exp=5", mem_back_rd_addr_o); end
        checks++; if (mem_back_csr_wreg_o !== 1'b1) begin failures++; $display("FAIL alu_csr_wreg got=%b exp=1", mem_back_csr_wreg_o); end
        checks++; if (mem_back_csr_waddr_o !== 12'h300) begin failures++; $display("FAIL alu_csr_waddr got=%h exp=300", mem_back_csr_waddr_o); end
        tick();
        checks++; if (wb_valid_o !== 1'b0) begin failures++; $display("FAIL alu_wb_drop got=%b exp=0", wb_valid_o); end
        checks++; if (mem_back_wreg_o !== 1'b0) begin failures++; $display("FAIL alu_wreg_drop got=%b exp=0", mem_back_wreg_o); end
        checks++; if (mem_back_csr_wreg_o !== 1'b0) begin failures++; $display("FAIL alu_csr_drop got=%b exp=0", mem_back_csr_wreg_o); end
        checks++; if (mem_back_wdata_o !== 64'h1234) begin failures++; $display("FAIL alu_hold got=%h exp=1234", mem_back_wdata_o); end
    endtask

    task automatic test_rd_zero;
        drive_op(7'b0110011, 3'b000, 64'h77, 64'h0, 5'd0, 1'b1);
        tick();
        idle_inputs();
        checks++; if (wb_valid_o !== 1'b1) begin failures++; $display("FAIL rd0_wb_valid got=%b exp=1", wb_valid_o); end
        checks++; if (mem_back_wreg_o !== 1'b0) begin failures++; $display("FAIL rd0_wreg got=%b exp=0", mem_back_wreg_o); end
        tick();
    endtask

    task automatic test_loads;
        for (int i = 0; i < 7; i++) begin
            drive_op(7'b0000011, ld_f3[i], ld_addr[i], 64'h0, 5'(10 + i), 1'b1);
            tick();
            idle_inputs();
            checks++; if (mif.dmem_req !== 1'b1) begin failures++; $display("FAIL ld%0d_req got=%b exp=1", i, mif.dmem_req); end
            checks++; if (mif.dmem_addr !== (ld_addr[i] & ~64'h7)) begin failures++; $display("FAIL ld%0d_addr got=%h exp=%h", i, mif.dmem_addr, ld_addr[i] & ~64'h7); end
            checks++; if (mif.dmem_we !== 1'b0) begin failures++; $display("FAIL ld%0d_we got=%b exp=0", i, mif.dmem_we); end
            checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL ld%0d_busy got=%b exp=0", i, ready_o); end
            mif.dmem_ack   = 1'b1;
            mif.dmem_rdata = RDATA;
            tick();
            mif.dmem_ack   = 1'b0;
            checks++; if (wb_valid_o !== 1'b1) begin failures++; $display("FAIL ld%0d_wb_valid got=%b exp=1", i, wb_valid_o); end
            checks++; if (mem_back_wdata_o !== ld_exp[i]) begin failures++; $display("FAIL ld%0d_data got=%h exp=%h", i, mem_back_wdata_o, ld_exp[i]); end
            checks++; if (mem_back_wreg_o !== 1'b1) begin failures++; $display("FAIL ld%0d_wreg got=%b exp=1", i, mem_back_wreg_o); end
            checks++; if (mem_back_rd_addr_o !== 5'(10 + i)) begin failures++; $display("FAIL ld%0d_rd got=%0d exp=%0d", i, mem_back_rd_addr_o, 10 + i); end
            checks++; if (mif.dmem_req !== 1'b0) begin failures++; $display("FAIL ld%0d_req_drop got=%b exp=0", i, mif.dmem_req); end
            tick();
            checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL ld%0d_ready got=%b exp=1", i, ready_o); end
            checks++; if (wb_valid_o !== 1'b0) begin failures++; $display("FAIL ld%0d_wb_once got=%b exp=0", i, wb_valid_o); end
        end
    endtask

    task automatic test_lb_slow_ack;
        drive_op(7'b0000011, 3'b000, 64'h1003, 64'h0, 5'd3, 1'b1);
        tick();
        // EX tries to push another op while busy; it must be ignored.
        drive_op(7'b0110011, 3'b000, 64'h5555, 64'h0, 5'd9, 1'b1);
        tick();
        checks++; if (mif.dmem_req !== 1'b1) begin failures++; $display("FAIL lbslow_req_held got=%b exp=1", mif.dmem_req); end
        checks++; if (wb_valid_o !== 1'b0) begin failures++; $display("FAIL lbslow_no_wb got=%b exp=0", wb_valid_o); end
        mif.dmem_ack   = 1'b1;
        mif.dmem_rdata = 64'h0000_0000_8000_0000;
        tick();
        mif.dmem_ack   = 1'b0;
        idle_inputs();
        checks++; if (mem_back_wdata_o !== 64'hFFFF_FFFF_FFFF_FF80) begin failures++; $display("FAIL lbslow_data got=%h exp=ffffffffffffff80", mem_back_wdata_o); end
        checks++; if (mem_back_rd_addr_o !== 5'd3) begin failures++; $display("FAIL lbslow_rd got=%0d exp=3", mem_back_rd_addr_o); end
        tick();
        checks++; if (mem_back_wdata_o !== 64'hFFFF_FFFF_FFFF_FF80) begin failures++; $display("FAIL lbslow_ignored got=%h exp=ffffffffffffff80", mem_back_wdata_o); end
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL lbslow_ready got=%b exp=1", ready_o); end
    endtask

    task automatic test_stores;
        for (int i = 0; i < 4; i++) begin
            drive_op(7'b0100011, st_f3[i], st_addr[i], st_data[i], 5'd7, 1'b1);
            tick();
            idle_inputs();
            checks++; if (mif.dmem_req !== 1'b1 || mif.dmem_we !== 1'b1) begin failures++; $display("FAIL st%0d_req_we got=%b%b exp=11", i, mif.dmem_req, mif.dmem_we); end
            checks++; if (mif.dmem_addr !== (st_addr[i] & ~64'h7)) begin failures++; $display("FAIL st%0d_addr got=%h exp=%h", i, mif.dmem_addr, st_addr[i] & ~64'h7); end
            checks++; if (mif.dmem_wmask !== st_mask[i]) begin failures++; $display("FAIL st%0d_mask got=%h exp=%h", i, mif.dmem_wmask, st_mask[i]); end
            checks++; if (mif.dmem_wdata !== st_lane[i]) begin failures++; $display("FAIL st%0d_wdata got=%h exp=%h", i, mif.dmem_wdata, st_lane[i]); end
            mif.dmem_ack = 1'b1;
            tick();
            mif.dmem_ack = 1'b0;
            checks++; if (wb_valid_o !== 1'b1) begin failures++; $display("FAIL st%0d_wb_valid got=%b exp=1", i, wb_valid_o); end
            checks++; if (mem_back_wreg_o !== 1'b0) begin failures++; $display("FAIL st%0d_wreg got=%b exp=0", i, mem_back_wreg_o); end
            tick();
        end
    endtask

    task automatic test_bad_funct3;
        drive_op(7'b0000011, 3'b111, 64'h1000, 64'h0, 5'd4, 1'b1);
        tick();
        idle_inputs();
        checks++; if (mif.dmem_req !== 1'b0) begin failures++; $display("FAIL badf3_req got=%b exp=0", mif.dmem_req); end
        checks++; if (wb_valid_o !== 1'b1) begin failures++; $display("FAIL badf3_wb_valid got=%b exp=1", wb_valid_o); end
        checks++; if (mem_back_wreg_o !== 1'b0) begin failures++; $display("FAIL badf3_wreg got=%b exp=0", mem_back_wreg_o); end
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL badf3_ready got=%b exp=1", ready_o); end
        tick();
    endtask

    task automatic test_misalign;
        drive_op(7'b0000011, 3'b010, 64'h1002, 64'h0, 5'd6, 1'b1);
        tick();
        idle_inputs();
`ifdef MEM_MISALIGN_TRAP_EN
        checks++; if (mif.dmem_req !== 1'b0) begin failures++; $display("FAIL mis_req got=%b exp=0", mif.dmem_req); end
        checks++; if (misalign_o !== 1'b1) begin failures++; $display("FAIL mis_flag got=%b exp=1", misalign_o); end
        checks++; if (wb_valid_o !== 1'b1 || mem_back_wreg_o !== 1'b0) begin failures++; $display("FAIL mis_wb got=%b%b exp=10", wb_valid_o, mem_back_wreg_o); end
        tick();
        checks++; if (misalign_o !== 1'b0) begin failures++; $display("FAIL mis_pulse got=%b exp=0", misalign_o); end
`else
        checks++; if (mif.dmem_req !== 1'b1 || mif.dmem_addr !== 64'h1000) begin failures++; $display("FAIL mis_req got=%b/%h exp=1/1000", mif.dmem_req, mif.dmem_addr); end
        mif.dmem_ack   = 1'b1;
        mif.dmem_rdata = RDATA;
        tick();
        mif.dmem_ack   = 1'b0;
        checks++; if (mem_back_wdata_o !== 64'hFFFF_FFFF_B4A5_9687) begin failures++; $display("FAIL mis_lane0 got=%h exp=ffffffffb4a59687", mem_back_wdata_o); end
        tick();
`endif
    endtask

    task automatic test_timeout;
        int n;
        drive_op(7'b0000011, 3'b011, 64'h3000, 64'h0, 5'd8, 1'b1);
        tick();
        idle_inputs();
        n = 0;
        while (bus_err_o !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        checks++; if (n != 255) begin failures++; $display("FAIL timeout_cycles got=%0d exp=255", n); end
        checks++; if (wb_valid_o !== 1'b1 || mem_back_wreg_o !== 1'b0) begin failures++; $display("FAIL timeout_wb got=%b%b exp=10", wb_valid_o, mem_back_wreg_o); end
        checks++; if (ready_o !== 1'b1 || mif.dmem_req !== 1'b0) begin failures++; $display("FAIL timeout_ready_req got=%b%b exp=10", ready_o, mif.dmem_req); end
        tick();
        checks++; if (bus_err_o !== 1'b0) begin failures++; $display("FAIL timeout_pulse got=%b exp=0", bus_err_o); end
    endtask

    task automatic test_reset_mid;
        drive_op(7'b0000011, 3'b010, 64'h1000, 64'h0, 5'd2, 1'b1);
        tick();
        idle_inputs();
        checks++; if (mif.dmem_req !== 1'b1) begin failures++; $display("FAIL rstmid_req got=%b exp=1", mif.dmem_req); end
        #2 rst = 1'b0;
        #1;
        checks++; if (mif.dmem_req !== 1'b0) begin failures++; $display("FAIL rstmid_drop got=%b exp=0", mif.dmem_req); end
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b exp=1", ready_o); end
        #2 rst = 1'b1;
        tick();
        checks++; if (ready_o !== 1'b1 || mif.dmem_req !== 1'b0) begin failures++; $display("FAIL rstmid_after got=%b%b exp=10", ready_o, mif.dmem_req); end
    endtask

    task automatic test_back_to_back;
        drive_op(7'b0110011, 3'b000, 64'hAAAA, 64'h0, 5'd1, 1'b1);
        tick();
        checks++; if (wb_valid_o !== 1'b1 || mem_back_wdata_o !== 64'hAAAA) begin failures++; $display("FAIL b2b_first got=%b/%h exp=1/aaaa", wb_valid_o, mem_back_wdata_o); end
        drive_op(7'b0110011, 3'b000, 64'hBBBB, 64'h0, 5'd2, 1'b1);
        tick();
        idle_inputs();
        checks++; if (wb_valid_o !== 1'b1 || mem_back_wdata_o !== 64'hBBBB) begin failures++; $display("FAIL b2b_second got=%b/%h exp=1/bbbb", wb_valid_o, mem_back_wdata_o); end
        checks++; if (mem_back_rd_addr_o !== 5'd2) begin failures++; $display("FAIL b2b_rd got=%0d exp=2", mem_back_rd_addr_o); end
        tick();
        checks++; if (wb_valid_o !== 1'b0) begin failures++; $display("FAIL b2b_end got=%b exp=0", wb_valid_o); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_rd_zero();
        test_loads();
        test_lb_slow_ack();
        test_stores();
        test_bad_funct3();
        test_misalign();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
